// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file sequencer.
//   - opcode encodings OP_NOP..OP_HALT
//   - instruction field slice positions
//   - sequencer state encoding (ST_INIT is only reached when the
//     build defines RF_INIT_SWEEP_EN)
package rf_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_MOV  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;
   localparam logic [3:0] OP_NOT  = 4'h8;
   localparam logic [3:0] OP_INC  = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam int unsigned OPC_MSB  = 15;
   localparam int unsigned OPC_LSB  = 12;
   localparam int unsigned DEST_MSB = 11;
   localparam int unsigned DEST_LSB = 9;
   localparam int unsigned SRCA_MSB = 8;
   localparam int unsigned SRCA_LSB = 6;
   localparam int unsigned SRCB_MSB = 5;
   localparam int unsigned SRCB_LSB = 3;
   localparam int unsigned IMM_MSB  = 7;
   localparam int unsigned IMM_LSB  = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_EXEC,
      ST_WB,
      ST_HALT,
      ST_INIT
   } state_e;

endpackage

// File: rtl/rf_sequencer_if.sv
// rf_sequencer_if: instruction handshake plus register-file/ALU control bus.
//   master : instruction source / datapath side (drives instr, instr_valid)
//   slave  : rf_sequencer side (drives instr_ready and all control outputs)
interface rf_sequencer_if #(
   parameter int unsigned DW  = 8,
   parameter int unsigned RAW = 3,
   parameter int unsigned IW  = 16
) ();

   logic [IW-1:0]  instr;
   logic           instr_valid;
   logic           instr_ready;
   logic [RAW-1:0] AA;
   logic [RAW-1:0] BA;
   logic [RAW-1:0] DA;
   logic           RW;
   logic [3:0]     FS;
   logic           MD;
   logic [DW-1:0]  imm;
   logic           op_load;
   logic           done;
   logic           halted;
   logic           illegal;

   modport master (
      output instr, instr_valid,
      input  instr_ready, AA, BA, DA, RW, FS, MD, imm, op_load, done, halted, illegal
   );

   modport slave (
      input  instr, instr_valid,
      output instr_ready, AA, BA, DA, RW, FS, MD, imm, op_load, done, halted, illegal
   );

endinterface

// File: rtl/rf_decoder.sv
// rf_decoder: combinational opcode classification.
//   opcode     in  : instruction opcode field
//   uses_alu   out : MOV/ADD/SUB/AND/OR/XOR/NOT/INC (read, exec, write back)
//   uses_imm   out : LDI (write immediate)
//   is_halt    out : HALT
//   is_illegal out : opcodes 0xA..0xE
module rf_decoder
   import rf_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       uses_alu,
   output logic       uses_imm,
   output logic       is_halt,
   output logic       is_illegal
);

   always_comb begin
      uses_alu   = 1'b0;
      uses_imm   = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      case (opcode)
         OP_NOP: ;
         OP_LDI: uses_imm = 1'b1;
         OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_NOT, OP_INC: uses_alu = 1'b1;
         OP_HALT: is_halt = 1'b1;
         default: is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/rf_sequencer.sv
// rf_sequencer: multi-cycle control unit for the 8x8 register-file datapath.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : rf_sequencer_if.slave -- instr/instr_valid/instr_ready handshake,
//           AA/BA/DA selects, RW, FS, MD, imm, op_load, done, halted, illegal
// Build option RF_INIT_SWEEP_EN: after reset, sweep zeros into R0..R7
// (one register per cycle) before accepting instructions.
module rf_sequencer
   import rf_pkg::*;
#(
   parameter int unsigned DW  = 8,
   parameter int unsigned RAW = 3,
   parameter int unsigned IW  = 16
) (
   input  logic          clk,
   input  logic          reset,
   rf_sequencer_if.slave bus
);

   state_e         state_q, state_d;
   logic [RAW-1:0] aa_q, aa_d;
   logic [RAW-1:0] ba_q, ba_d;
   logic [RAW-1:0] da_q, da_d;
   logic [3:0]     fs_q, fs_d;
   logic [DW-1:0]  imm_q, imm_d;
   logic           md_q, md_d;
   logic           illegal_q, illegal_d;
   logic           nop_done_q, nop_done_d;

   logic uses_alu, uses_imm, is_halt, is_illegal;
   logic transfer;

`ifdef RF_INIT_SWEEP_EN
   logic [RAW-1:0] init_cnt_q, init_cnt_d;
   localparam state_e RESET_STATE = ST_INIT;
`else
   localparam state_e RESET_STATE = ST_IDLE;
`endif

   // Decode the incoming word so the first post-acceptance state can
   // already be WB (LDI), HALT, or IDLE (NOP/illegal).
   rf_decoder u_decoder (
      .opcode    (bus.instr[OPC_MSB:OPC_LSB]),
      .uses_alu  (uses_alu),
      .uses_imm  (uses_imm),
      .is_halt   (is_halt),
      .is_illegal(is_illegal)
   );

   assign transfer = bus.instr_valid && (state_q == ST_IDLE);

   always_comb begin
      state_d    = state_q;
      aa_d       = aa_q;
      ba_d       = ba_q;
      da_d       = da_q;
      fs_d       = fs_q;
      imm_d      = imm_q;
      md_d       = md_q;
      illegal_d  = illegal_q;
      nop_done_d = 1'b0;
`ifdef RF_INIT_SWEEP_EN
      init_cnt_d = init_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (transfer) begin
               aa_d  = bus.instr[SRCA_MSB:SRCA_LSB];
               ba_d  = bus.instr[SRCB_MSB:SRCB_LSB];
               da_d  = bus.instr[DEST_MSB:DEST_LSB];
               fs_d  = bus.instr[OPC_MSB:OPC_LSB];
               imm_d = bus.instr[IMM_MSB:IMM_LSB];
               md_d  = uses_imm;
               if (uses_imm) begin
                  state_d = ST_WB;
               end else if (is_halt) begin
                  state_d = ST_HALT;
               end else if (uses_alu) begin
                  state_d = ST_READ;
               end else begin
                  // NOP and undefined opcodes retire next cycle from IDLE.
                  nop_done_d = 1'b1;
                  illegal_d  = illegal_q | is_illegal;
               end
            end
         end
         ST_READ: state_d = ST_EXEC;
         ST_EXEC: state_d = ST_WB;
         ST_WB:   state_d = ST_IDLE;
         ST_HALT: state_d = ST_HALT;
         ST_INIT: begin
`ifdef RF_INIT_SWEEP_EN
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == '1) begin
               state_d = ST_IDLE;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pulses are masked while reset is high so a reset landing in WB
   // aborts the write in that same cycle.
   always_comb begin
      bus.instr_ready = (state_q == ST_IDLE);
      bus.AA          = aa_q;
      bus.BA          = ba_q;
      bus.DA          = da_q;
      bus.FS          = fs_q;
      bus.imm         = imm_q;
      bus.op_load     = !reset && (state_q == ST_READ);
      bus.RW          = !reset && (state_q == ST_WB);
      bus.MD          = !reset && (state_q == ST_WB) && md_q;
      bus.done        = !reset && ((state_q == ST_WB) || nop_done_q);
      bus.halted      = (state_q == ST_HALT);
      bus.illegal     = illegal_q;
`ifdef RF_INIT_SWEEP_EN
      if (state_q == ST_INIT) begin
         bus.RW  = !reset;
         bus.MD  = !reset;
         bus.DA  = init_cnt_q;
         bus.imm = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RESET_STATE;
         aa_q       <= '0;
         ba_q       <= '0;
         da_q       <= '0;
         fs_q       <= '0;
         imm_q      <= '0;
         md_q       <= 1'b0;
         illegal_q  <= 1'b0;
         nop_done_q <= 1'b0;
`ifdef RF_INIT_SWEEP_EN
         init_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         aa_q       <= aa_d;
         ba_q       <= ba_d;
         da_q       <= da_d;
         fs_q       <= fs_d;
         imm_q      <= imm_d;
         md_q       <= md_d;
         illegal_q  <= illegal_d;
         nop_done_q <= nop_done_d;
`ifdef RF_INIT_SWEEP_EN
         init_cnt_q <= init_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_rf_sequencer.sv
// tb_rf_sequencer: directed self-checking bench for rf_sequencer.
// Honors RF_INIT_SWEEP_EN when the same macro is defined for the build.
module tb_rf_sequencer;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   int unsigned checks = 0;
   int unsigned errors = 0;

   rf_sequencer_if #(.DW(8), .RAW(3), .IW(16)) bus ();

   rf_sequencer #(.DW(8), .RAW(3), .IW(16)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset           = 1'b1;
      bus.instr_valid = 1'b0;
      check_eq("rst_rw_masked", {31'd0, bus.RW}, 32'd0);
      tick();
      reset = 1'b0;
`ifdef RF_INIT_SWEEP_EN
      for (int i = 0; i < 8; i++) begin
         check_eq("init_rw",    {31'd0, bus.RW}, 32'd1);
         check_eq("init_da",    {29'd0, bus.DA}, i);
         check_eq("init_md",    {31'd0, bus.MD}, 32'd1);
         check_eq("init_imm",   {24'd0, bus.imm}, 32'd0);
         check_eq("init_ready", {31'd0, bus.instr_ready}, 32'd0);
         tick();
      end
`endif
   endtask

   task automatic check_reset_values();
      check_eq("rv_ready",   {31'd0, bus.instr_ready}, 32'd1);
      check_eq("rv_aa",      {29'd0, bus.AA}, 32'd0);
      check_eq("rv_ba",      {29'd0, bus.BA}, 32'd0);
      check_eq("rv_da",      {29'd0, bus.DA}, 32'd0);
      check_eq("rv_fs",      {28'd0, bus.FS}, 32'd0);
      check_eq("rv_md",      {31'd0, bus.MD}, 32'd0);
      check_eq("rv_imm",     {24'd0, bus.imm}, 32'd0);
      check_eq("rv_rw",      {31'd0, bus.RW}, 32'd0);
      check_eq("rv_op_load", {31'd0, bus.op_load}, 32'd0);
      check_eq("rv_done",    {31'd0, bus.done}, 32'd0);
      check_eq("rv_halted",  {31'd0, bus.halted}, 32'd0);
      check_eq("rv_illegal", {31'd0, bus.illegal}, 32'd0);
   endtask

   // Present one word for a single cycle; the sequencer must be ready.
   task automatic issue(input logic [15:0] w);
      bus.instr       = w;
      bus.instr_valid = 1'b1;
      check_eq("issue_ready", {31'd0, bus.instr_ready}, 32'd1);
      tick();
      bus.instr_valid = 1'b0;
   endtask

   initial begin
      int unsigned acc;
      int unsigned rw_n;
      int unsigned acc_cyc [2];
      logic [2:0]  rw_da [2];

      bus.instr       = '0;
      bus.instr_valid = 1'b0;
      tick();
      do_reset();
      check_reset_values();

      // LDI R3,#0x5A
      issue(16'h165A);
      check_eq("ldi_rw",    {31'd0, bus.RW}, 32'd1);
      check_eq("ldi_da",    {29'd0, bus.DA}, 32'd3);
      check_eq("ldi_md",    {31'd0, bus.MD}, 32'd1);
      check_eq("ldi_imm",   {24'd0, bus.imm}, 32'h5A);
      check_eq("ldi_done",  {31'd0, bus.done}, 32'd1);
      check_eq("ldi_busy",  {31'd0, bus.instr_ready}, 32'd0);
      tick();
      check_eq("ldi_ready", {31'd0, bus.instr_ready}, 32'd1);
      check_eq("ldi_rw_end", {31'd0, bus.RW}, 32'd0);

      // ADD R2,R3,R3
      issue(16'h34D8);
      check_eq("add_op_load", {31'd0, bus.op_load}, 32'd1);
      check_eq("add_aa",      {29'd0, bus.AA}, 32'd3);
      check_eq("add_ba",      {29'd0, bus.BA}, 32'd3);
      check_eq("add_rw_t1",   {31'd0, bus.RW}, 32'd0);
      tick();
      check_eq("add_fs",      {28'd0, bus.FS}, 32'd3);
      check_eq("add_op_load_t2", {31'd0, bus.op_load}, 32'd0);
      check_eq("add_rw_t2",   {31'd0, bus.RW}, 32'd0);
      tick();
      check_eq("add_rw",      {31'd0, bus.RW}, 32'd1);
      check_eq("add_da",      {29'd0, bus.DA}, 32'd2);
      check_eq("add_md",      {31'd0, bus.MD}, 32'd0);
      check_eq("add_done",    {31'd0, bus.done}, 32'd1);
      check_eq("add_busy_t3", {31'd0, bus.instr_ready}, 32'd0);
      tick();
      check_eq("add_ready_t4", {31'd0, bus.instr_ready}, 32'd1);

      // Back-to-back: SUB R1,R2,R3 then XOR R4,R5,R6 with valid held high
      acc  = 0;
      rw_n = 0;
      bus.instr       = 16'h4298;
      bus.instr_valid = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (bus.instr_valid && bus.instr_ready) begin
            if (acc < 2) acc_cyc[acc] = cyc;
            acc++;
         end
         if (bus.RW) begin
            if (rw_n < 2) rw_da[rw_n] = bus.DA;
            rw_n++;
         end
         tick();
         if (acc == 1) bus.instr = 16'h7970;
         if (acc >= 2) bus.instr_valid = 1'b0;
      end
      check_eq("b2b_accepts", acc, 32'd2);
      check_eq("b2b_rw_count", rw_n, 32'd2);
      if (acc == 2) check_eq("b2b_spacing", acc_cyc[1] - acc_cyc[0], 32'd4);
      if (rw_n == 2) begin
         check_eq("b2b_da0", {29'd0, rw_da[0]}, 32'd1);
         check_eq("b2b_da1", {29'd0, rw_da[1]}, 32'd4);
      end

      // Undefined opcode 0xB
      issue(16'hB000);
      check_eq("ill_rw",      {31'd0, bus.RW}, 32'd0);
      check_eq("ill_done",    {31'd0, bus.done}, 32'd1);
      check_eq("ill_flag",    {31'd0, bus.illegal}, 32'd1);
      check_eq("ill_ready",   {31'd0, bus.instr_ready}, 32'd1);
      tick();
      check_eq("ill_done_end", {31'd0, bus.done}, 32'd0);
      check_eq("ill_sticky",  {31'd0, bus.illegal}, 32'd1);

      // NOP
      issue(16'h0000);
      check_eq("nop_done",    {31'd0, bus.done}, 32'd1);
      check_eq("nop_rw",      {31'd0, bus.RW}, 32'd0);
      check_eq("nop_sticky",  {31'd0, bus.illegal}, 32'd1);

      // Reset during EXEC of SUB R1,R2,R3
      tick();
      issue(16'h4298);
      check_eq("sub_op_load", {31'd0, bus.op_load}, 32'd1);
      check_eq("sub_aa",      {29'd0, bus.AA}, 32'd2);
      tick();
      check_eq("sub_fs",      {28'd0, bus.FS}, 32'd4);
      do_reset();
      check_reset_values();
      tick();
      check_eq("sub_no_late_rw", {31'd0, bus.RW}, 32'd0);

      // HALT, then more valid words
      issue(16'hF000);
      check_eq("halt_halted", {31'd0, bus.halted}, 32'd1);
      check_eq("halt_ready",  {31'd0, bus.instr_ready}, 32'd0);
      bus.instr       = 16'h165A;
      bus.instr_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("halt_rw",     {31'd0, bus.RW}, 32'd0);
         check_eq("halt_stays",  {31'd0, bus.halted}, 32'd1);
         check_eq("halt_ready2", {31'd0, bus.instr_ready}, 32'd0);
      end
      do_reset();
      check_reset_values();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
